// File: rtl/load_store_unit.sv
// Multi-cycle data-memory stage: lane steering, load extension, bus timeout.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRW,
    input  logic [1:0]  mem_width,
    input  logic        mem_signed_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic        resp_wen,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic          signed_q;
    logic          err_q;
    logic [1:0]    width_q;
    logic [1:0]    off_q;

    logic [1:0]    off;
    logic [3:0]    strb;
    logic [31:0]   wsteer;
    logic          req_err;
    logic [31:0]   shifted;
    logic [31:0]   ld;

    // Half and word offsets are forced to natural alignment.
    always_comb begin
        off    = 2'b00;
        strb   = 4'b0000;
        wsteer = 32'h0;
        unique case (1'b1)
            (mem_width == 2'b00): begin
                off    = addr[1:0];
                strb   = 4'b0001 << addr[1:0];
                wsteer = {4{wdata[7:0]}};
            end
            (mem_width == 2'b01): begin
                off    = {addr[1], 1'b0};
                strb   = 4'b0011 << {addr[1], 1'b0};
                wsteer = {2{wdata[15:0]}};
            end
            (mem_width == 2'b10): begin
                strb   = 4'b1111;
                wsteer = wdata;
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal   = ((mem_width == 2'b01) & addr[0])
                   | ((mem_width == 2'b10) & (|addr[1:0]));
    assign req_err = (&mem_width) | misal;
`else
    assign req_err = &mem_width;
`endif

    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ld = shifted;
        unique case (1'b1)
            (width_q == 2'b00):
                ld = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            (width_q == 2'b01):
                ld = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            width_q   <= 2'b00;
            off_q     <= 2'b00;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_wstrb <= 4'h0;
            resp_rd   <= 5'd0;
            resp_data <= 32'h0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (req_valid) begin
                        rw_q      <= MemRW;
                        signed_q  <= mem_signed_read;
                        width_q   <= mem_width;
                        off_q     <= off;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= MemRW ? 32'h0 : wsteer;
                        bus_wstrb <= MemRW ? 4'h0 : strb;
                        resp_rd   <= rd;
                        resp_data <= 32'h0;
                        cnt       <= '0;
                        err_q     <= req_err;
                        state     <= req_err ? RESP : BUS;
                    end
                end
                (state == BUS): begin
                    cnt <= cnt + 1'b1;
                    // An ack on the final counted cycle still completes.
                    if (bus_ack) begin
                        resp_data <= rw_q ? ld : 32'h0;
                        err_q     <= 1'b0;
                        state     <= RESP;
                    end else if (TIMEOUT != 0 && cnt == LAST) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                (state == RESP): begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign bus_req    = (state == BUS);
    assign bus_we     = bus_req & ~rw_q;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_wen   = resp_valid & rw_q & ~err_q & (|resp_rd);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan cases plus random ops vs a byte-lane model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemRW = 1'b0;
    logic [1:0]  mem_width = 2'b00;
    logic        mem_signed_read = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        resp_valid;
    logic        resp_wen;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    int          o_cycles;
    logic        o_stable;
    logic [31:0] o_addr, o_wdata, o_data;
    logic [3:0]  o_strb;
    logic        o_we, o_valid, o_err, o_wen, o_valid_after, o_ready_after;
    logic [4:0]  o_rd;

    load_store_unit #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemRW(MemRW), .mem_width(mem_width),
        .mem_signed_read(mem_signed_read),
        .addr(addr), .wdata(wdata), .rd(rd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_valid(resp_valid), .resp_wen(resp_wen),
        .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Drives one request and records what the bus and response side did.
    task automatic run_op(input logic rw, input logic [1:0] w,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r,
                          input logic [31:0] rdv, input int ack_at);
        @(negedge clk);
        req_valid = 1'b1; MemRW = rw; mem_width = w;
        mem_signed_read = sg; addr = a; wdata = wd; rd = r;
        @(negedge clk);
        req_valid = 1'b0; addr = $urandom; wdata = $urandom;
        rd = 5'($urandom); MemRW = ~rw; mem_signed_read = ~sg;
        o_cycles = 0; o_stable = 1'b1;
        o_addr = 'x; o_wdata = 'x; o_strb = 'x; o_we = 'x;
        while (bus_req === 1'b1 && o_cycles < 50) begin
            o_cycles++;
            if (o_cycles == 1) begin
                o_addr = bus_addr; o_wdata = bus_wdata;
                o_strb = bus_wstrb; o_we = bus_we;
            end else if ({bus_addr, bus_wdata, bus_wstrb, bus_we}
                         !== {o_addr, o_wdata, o_strb, o_we}) begin
                o_stable = 1'b0;
            end
            bus_ack = (o_cycles == ack_at);
            bus_rdata = bus_ack ? rdv : $urandom;
            @(negedge clk);
            bus_ack = 1'b0;
        end
        o_valid = resp_valid; o_err = resp_err; o_wen = resp_wen;
        o_rd = resp_rd; o_data = resp_data;
        @(negedge clk);
        o_valid_after = resp_valid; o_ready_after = req_ready;
    endtask

    // Reference: works on byte lanes and access sizes, not on RTL encodings.
    task automatic model(input logic rw, input logic [1:0] w,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] r,
                         input logic [31:0] rdv, input int ack_at,
                         output int e_cycles, output logic [31:0] e_addr,
                         output logic [3:0] e_strb, output logic [31:0] e_wdata,
                         output logic [31:0] e_data, output logic e_err,
                         output logic e_wen);
        int size, ofs, lane;
        logic [31:0] v;
        logic bad, acked;
        size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
        bad = (size == 0);
        ofs = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size > 1 && (ofs % size) != 0) bad = 1'b1;
`endif
        lane = (size == 0) ? 0 : ofs - (ofs % size);
        e_addr = a - 32'(ofs);
        e_strb = 4'h0; e_wdata = 32'h0; v = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (size > 0) begin
                if (i >= lane && i < lane + size) e_strb[i] = ~rw;
                e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end
        for (int k = 0; k < size; k++) v[8*k +: 8] = rdv[8*(lane+k) +: 8];
        if (sg && size > 0 && size < 4 && v[8*size-1])
            for (int k = size; k < 4; k++) v[8*k +: 8] = 8'hFF;
        acked = (ack_at >= 1 && ack_at <= T);
        e_cycles = bad ? 0 : (acked ? ack_at : T);
        e_err = bad | ~acked;
        e_data = (rw && !e_err) ? v : 32'h0;
        e_wen = rw & ~e_err & (r != 5'd0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, bus_req, bus_we, resp_valid, resp_wen, resp_err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {req_ready, bus_req, bus_we, resp_valid, resp_wen, resp_err});
        end
        checks++;
        if ({bus_addr, bus_wdata, bus_wstrb, resp_rd, resp_data} !== 105'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {bus_addr, bus_wdata, bus_wstrb, resp_rd, resp_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_load_word;
        run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 1);
        checks++;
        if (o_cycles != 1 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL lw_latency: bus cycles %0d valid %b want 1 1", o_cycles, o_valid);
        end
        checks++;
        if (o_data !== 32'hDEADBEEF || o_wen !== 1'b1 || o_rd !== 5'd7 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL lw_resp: data %h wen %b rd %0d err %b want deadbeef 1 7 0",
                     o_data, o_wen, o_rd, o_err);
        end
        checks++;
        if (o_addr !== 32'h100 || o_we !== 1'b0 || o_strb !== 4'h0) begin
            errors++;
            $display("FAIL lw_bus: addr %h we %b strb %b want 100 0 0000", o_addr, o_we, o_strb);
        end
        checks++;
        if (o_valid_after !== 1'b0 || o_ready_after !== 1'b1) begin
            errors++;
            $display("FAIL lw_after: valid %b ready %b want 0 1", o_valid_after, o_ready_after);
        end
    endtask

    task automatic test_load_extend;
        run_op(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 5'd3, 32'h80FFFFFF, 1);
        checks++;
        if (o_data !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb: got %h want ffffff80", o_data);
        end
        run_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 32'h80FFFFFF, 2);
        checks++;
        if (o_data !== 32'h00000080) begin
            errors++; $display("FAIL lbu: got %h want 00000080", o_data);
        end
        run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 5'd4, 32'h80015A5A, 1);
        checks++;
        if (o_data !== 32'h00008001) begin
            errors++; $display("FAIL lhu: got %h want 00008001", o_data);
        end
    endtask

    task automatic test_store_byte;
        run_op(1'b0, 2'b00, 1'b0, 32'h202, 32'h000000AB, 5'd9, 32'h0, 1);
        checks++;
        if (o_wdata !== 32'hABABABAB || o_strb !== 4'b0100 || o_we !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: wdata %h strb %b we %b want abababab 0100 1",
                     o_wdata, o_strb, o_we);
        end
        checks++;
        if (o_wen !== 1'b0 || o_data !== 32'h0 || o_addr !== 32'h200) begin
            errors++;
            $display("FAIL sb_resp: wen %b data %h addr %h want 0 0 200", o_wen, o_data, o_addr);
        end
    endtask

    task automatic test_timeout;
        run_op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 5'd1, 32'h1234, 0);
        checks++;
        if (o_cycles != T || o_valid !== 1'b1 || o_err !== 1'b1 || o_wen !== 1'b0) begin
            errors++;
            $display("FAIL timeout: cycles %0d valid %b err %b wen %b want %0d 1 1 0",
                     o_cycles, o_valid, o_err, o_wen, T);
        end
        run_op(1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 5'd1, 32'h5555AAAA, T);
        checks++;
        if (o_cycles != T || o_err !== 1'b0 || o_data !== 32'h5555AAAA) begin
            errors++;
            $display("FAIL ack_at_limit: cycles %0d err %b data %h want %0d 0 5555aaaa",
                     o_cycles, o_err, o_data, T);
        end
    endtask

    task automatic test_misaligned;
        run_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 5'd5, 32'h12348765, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (o_cycles != 0 || o_err !== 1'b1 || o_wen !== 1'b0 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL lh_misaligned: cycles %0d err %b wen %b valid %b want 0 1 0 1",
                     o_cycles, o_err, o_wen, o_valid);
        end
`else
        checks++;
        if (o_addr !== 32'h100 || o_data !== 32'h00008765 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL lh_forced_align: addr %h data %h err %b want 100 00008765 0",
                     o_addr, o_data, o_err);
        end
`endif
        run_op(1'b0, 2'b11, 1'b0, 32'h300, 32'hFFFF, 5'd6, 32'h0, 1);
        checks++;
        if (o_cycles != 0 || o_err !== 1'b1 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_width: cycles %0d err %b valid %b want 0 1 1",
                     o_cycles, o_err, o_valid);
        end
    endtask

    task automatic test_rd_zero;
        run_op(1'b1, 2'b10, 1'b0, 32'h80, 32'h0, 5'd0, 32'hCAFEF00D, 2);
        checks++;
        if (o_wen !== 1'b0 || o_valid !== 1'b1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_zero: wen %b valid %b err %b want 0 1 0", o_wen, o_valid, o_err);
        end
    endtask

    task automatic test_ack_ignored;
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        bus_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_ack: unit reacted to ack while idle, want no change");
        end
    endtask

    task automatic test_reset_mid;
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; MemRW = 1'b1; mem_width = 2'b10;
        addr = 32'h500; rd = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL mid_start: bus_req %b want 1", bus_req);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || bus_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: bus_req %b ready %b valid %b addr %h want 0 1 0 0",
                     bus_req, req_ready, resp_valid, bus_addr);
        end
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || bus_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL mid_after: response or bus activity after reset, want none");
        end
    endtask

    task automatic test_random;
        logic rw, sg, e_err, e_wen;
        logic [1:0] w;
        logic [4:0] r;
        logic [31:0] a, wd, rdv, e_addr, e_wdata, e_data;
        logic [3:0] e_strb;
        int ack_at, e_cycles;
        for (int n = 0; n < 60; n++) begin
            rw = 1'($urandom); sg = 1'($urandom);
            w = 2'($urandom); r = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            a = $urandom; wd = $urandom; rdv = $urandom;
            ack_at = $urandom_range(0, T + 2);
            model(rw, w, sg, a, wd, r, rdv, ack_at,
                  e_cycles, e_addr, e_strb, e_wdata, e_data, e_err, e_wen);
            run_op(rw, w, sg, a, wd, r, rdv, ack_at);
            checks++;
            if (o_cycles != e_cycles || o_stable !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_bus_cycles: got %0d stable %b want %0d 1",
                         n, o_cycles, o_stable, e_cycles);
            end
            if (e_cycles > 0) begin
                checks++;
                if (o_addr !== e_addr || o_we !== ~rw) begin
                    errors++;
                    $display("FAIL rnd%0d_addr: addr %h we %b want %h %b",
                             n, o_addr, o_we, e_addr, ~rw);
                end
                checks++;
                if (o_strb !== e_strb || (!rw && o_wdata !== e_wdata)) begin
                    errors++;
                    $display("FAIL rnd%0d_store: strb %b wdata %h want %b %h",
                             n, o_strb, o_wdata, e_strb, e_wdata);
                end
            end
            checks++;
            if (o_valid !== 1'b1 || o_err !== e_err || o_wen !== e_wen || o_rd !== r) begin
                errors++;
                $display("FAIL rnd%0d_resp: valid %b err %b wen %b rd %0d want 1 %b %b %0d",
                         n, o_valid, o_err, o_wen, o_rd, e_err, e_wen, r);
            end
            checks++;
            if (o_data !== e_data) begin
                errors++;
                $display("FAIL rnd%0d_data: got %h want %h", n, o_data, e_data);
            end
            checks++;
            if (o_valid_after !== 1'b0 || o_ready_after !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_after: valid %b ready %b want 0 1",
                         n, o_valid_after, o_ready_after);
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_load_extend;
        test_store_byte;
        test_timeout;
        test_misaligned;
        test_rd_zero;
        test_ack_ignored;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the execute stage. Takes the ALU-computed effective address, store data, and the control decode's memory controls (`MemRW`, `mem_width`, `mem_signed_read`). Drives a word-addressed, variable-latency data bus with byte strobes. Returns a sign- or zero-extended load result, tagged with its destination register, to writeback.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles waiting for `bus_ack` before aborting; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute has a memory operation.
- `req_ready`  out  1  unit accepts a request this cycle.
- `MemRW`  in  1  1 = read (load), 0 = write (store).
- `mem_width`  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- `mem_signed_read`  in  1  1 = sign-extend load result, 0 = zero-extend.
- `addr`  in  32  effective byte address (ALU output).
- `wdata`  in  32  store data (rs2).
- `rd`  in  5  destination register of a load.
- `bus_req`  out  1  bus access pending.
- `bus_we`  out  1  1 = write access.
- `bus_addr`  out  32  `{addr[31:2],2'b00}`.
- `bus_wdata`  out  32  lane-steered store data.
- `bus_wstrb`  out  4  byte-lane write enables.
- `bus_ack`  in  1  bus completes the access this cycle.
- `bus_rdata`  in  32  read word; valid when `bus_ack`=1.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_wen`  out  1  writeback must write `resp_data` to `resp_rd`.
- `resp_rd`  out  5  destination register.
- `resp_data`  out  32  extended load data.
- `resp_err`  out  1  the access failed (misaligned, illegal width, or timeout).

## Operation
- FSM states: IDLE, BUS, RESP. Reset enters IDLE.
- Reset values: `req_ready`=1, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wstrb`=0, `resp_valid`=0, `resp_wen`=0, `resp_rd`=0, `resp_data`=0, `resp_err`=0. Timeout counter is 0.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, all request fields are latched.
  - Error request (illegal width, or misaligned when checking is enabled): go to RESP with `resp_err`=1 and no bus access.
  - Otherwise: go to BUS.
- BUS:
  - `bus_req`=1. Address, strobes and data are held stable.
  - The counter increments each cycle.
  - On `bus_ack`: capture the load result and go to RESP with `resp_err`=0.
  - If the counter reaches `TIMEOUT` (nonzero) with no ack: drop `bus_req` and go to RESP with `resp_err`=1.
- RESP:
  - `resp_valid`=1 for exactly one cycle. `resp_wen` = `MemRW & ~resp_err & (rd!=0)`.
  - Then go to IDLE and clear the counter.
- Store lane steering:
  - Byte: `bus_wdata={4{wdata[7:0]}}`, `bus_wstrb=4'b0001<<addr[1:0]`.
  - Half: `bus_wdata={2{wdata[15:0]}}`, `bus_wstrb=4'b0011<<{addr[1],1'b0}`.
  - Word: `bus_wdata=wdata`, `bus_wstrb=4'b1111`.
- Loads: `bus_wstrb`=0.
- Load extraction: `shifted = bus_rdata >> (8*addr[1:0])`.
  - Byte: extend from bit 7. Half: extend from bit 15. Word: no extension, `mem_signed_read` ignored.
- Stores and errors: `resp_data`=0.

## Timing
- Request accepted in cycle N → `bus_req` high from N+1.
- Ack in cycle M≥N+1 → `resp_valid` in M+1 → `req_ready` in M+2.
- Minimum occupancy: accept (N), BUS (N+1), RESP (N+2), IDLE (N+3). One request in flight at a time.
- `req_ready`=0 in BUS and RESP.
- `bus_ack` outside BUS is ignored.
- An error request goes accept → RESP in the next cycle; no bus cycle occurs.
- Timeout: `TIMEOUT`=T with no ack → BUS lasts exactly T cycles, then RESP.
- An ack in the same cycle the counter reaches T wins; the access completes normally.
- Reset asserted mid-access: next cycle is IDLE with reset values. `bus_req` is dropped immediately and no `resp_valid` is issued. The bus must tolerate an abandoned request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A half at odd `addr`, or a word with `addr[1:0]!=0`, is an error request: `resp_err`=1, `resp_wen`=0, no bus access.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misalignment is never flagged.
  - Half uses `addr[1]` only and word ignores `addr[1:0]`, i.e. the access is forced to its natural alignment.
  - Illegal width (11) is still an error.

## Test plan
- LW at 0x100, `bus_rdata`=0xDEADBEEF, ack in first BUS cycle → `resp_valid` 2 cycles after accept, `resp_data`=0xDEADBEEF, `resp_wen`=1.
- LB signed at 0x103, rdata=0x80FFFFFF → `resp_data`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 with rdata=0x8001xxxx → 0x00008001.
- SB at 0x202, `wdata`=0x000000AB → `bus_wdata`=0xABABABAB, `bus_wstrb`=0100, `bus_we`=1, `resp_wen`=0.
- LW with no ack, `TIMEOUT`=4 → `bus_req` high exactly 4 cycles, then `resp_valid`=1, `resp_err`=1.
- LH at 0x101: with the macro → `resp_err`=1 and `bus_req` never rises. Without the macro → `bus_addr`=0x100, low half returned.
- Reset asserted during BUS → next cycle `bus_req`=0, `req_ready`=1, no `resp_valid`. Load to `rd`=0 → `resp_wen`=0.
